multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 128 ++++++++++++
 tb/tb_multdiv_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign applied at the end.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;      // |A| for multiply, |B| for divide
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial hi, multiplier} or {remainder, quotient}
  logic               neg_q, neg_d;
  logic               mul_q, mul_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quo_s;

  assign start = ctrl_MULT | ctrl_DIV;
  // Unsigned negation gives the right magnitude even for the most negative value.
  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_s   = neg_q ? -acc_q : acc_q;
  assign prod_top = prod_s[2*WIDTH-1:WIDTH-1];
  assign quo_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    mul_d    = mul_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (start) begin
      state_d = ctrl_MULT ? MUL : DIV;
      cnt_d   = '0;
      mul_d   = ctrl_MULT;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      mag_d   = ctrl_MULT ? mag_a : mag_b;
      acc_d   = {{WIDTH{1'b0}}, ctrl_MULT ? mag_b : mag_a};
    end else begin
      unique case (state_q)
        MUL, DIV: begin
          acc_d = (state_q == MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (mul_q) begin
            result_d = prod_s[WIDTH-1:0];
            exc_d    = !((&prod_top) || !(|prod_top));
          end else if (mag_q == '0) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo_s;
            // Only a positive quotient of 2^(WIDTH-1) (MIN / -1) is unrepresentable.
            exc_d    = !neg_q && acc_q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      mul_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors push expected results,
// a negedge monitor pops and checks value, exception and arrival edge.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .clr           (clr),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (op_a),
    .data_operandB (op_b),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RDY must match the oldest expectation, on its exact edge.
  always @(negedge clk) begin
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'(data_resultRDY), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(data_result), 64'(e.res));
        check("exception", 64'(data_exception), 64'(e.exc));
        check("rdy_edge", 64'(cyc), 64'(e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("rdy_timeout", 64'(cyc), 64'(e.due));
    end
  end

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eres, input logic eexc, input bit track);
    @(negedge clk);
    ctrl_MULT = m; ctrl_DIV = d; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    op_a = ~a; op_b = b ^ 32'h1234_5678;   // later operand changes must be ignored
    if (track) sb.push_back('{eres, eexc, cyc + 33});
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic eexc);
    start_op(m, d, a, b, eres, eexc, 1'b1);
    check("hold_on_start", 64'({data_resultRDY, data_result}), 64'({1'b0, last_res}));
    repeat (35) @(posedge clk);
    #1;
    check("hold_after_rdy", 64'({data_exception, data_result}), 64'({eexc, eres}));
    last_res = eres;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got edge %0d expected < 5000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a start request held: it must be ignored until clr drops.
    #1 clr = 1'b1;
    ctrl_MULT = 1'b1; op_a = 32'd2; op_b = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exception", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clk) clr = 1'b0;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    sb.push_back('{32'd6, 1'b0, cyc + 33});
    repeat (35) @(posedge clk);
    last_res = 32'd6;

    // Multiply vectors
    run_op(1, 0, 32'd6,         32'd7,         32'h0000_002A, 1'b0);
    run_op(1, 0, 32'h4000_0000, 32'd4,         32'h0000_0000, 1'b1);
    run_op(1, 0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    run_op(1, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(1, 1, 32'd6,         32'd7,         32'h0000_002A, 1'b0);  // MULT wins over DIV

    // Divide vectors
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op(0, 1, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op(0, 1, 32'd5,         32'd0,         32'h0000_0000, 1'b1);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op(0, 1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
    run_op(0, 1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0);
    run_op(0, 1, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 1'b0);
    run_op(0, 1, 32'd1,         32'h8000_0000, 32'h0000_0000, 1'b0);
    run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(0, 1, 32'hFFFF_FFFE, 32'd3,         32'h0000_0000, 1'b0);  // -2/3 gives +0

    // Abort: MUL restarted by DIV at edge 10, only the DIV result may appear
    start_op(1, 0, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    run_op(0, 1, 32'd100, 32'd10, 32'h0000_000A, 1'b0);

    // clr between edges 12 and 13 of a MUL: outputs clear at once, no RDY follows
    start_op(1, 0, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_async", 64'({data_resultRDY, data_exception, data_result}), 64'd0);
    #1 clr = 1'b0;
    repeat (40) @(posedge clk);
    last_res = '0;
    run_op(1, 0, 32'd2, 32'd3, 32'h0000_0006, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
